// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and the registered flag bundle for the FIFO pointer/flag controller.
package fifo_ctrl_pkg;

   localparam int DEF_MEM_LENGHT      = 8;
   localparam int DEF_ADDR_WIDTH      = 3;
   localparam int DEF_ALMOST_FULL_TH  = 6;
   localparam int DEF_ALMOST_EMPTY_TH = 2;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } flags_t;

endpackage

// File: rtl/fifo_ctrl_ptr_counter.sv
// Wrapping pointer: advances by one when enabled, rolls over naturally at 2**W.
module fifo_ctrl_ptr_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: turns push/pop into storage addresses and enables,
// tracks occupancy, registered flags and a sticky overflow/underflow error.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int MEM_LENGHT      = DEF_MEM_LENGHT,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
   parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] write_ptr,
   output logic [ADDR_WIDTH-1:0] read_ptr,
   output logic                  write_enable,
   output logic                  read_enable,
   output logic                  data_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  fifo_error
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(MEM_LENGHT);
   localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL_TH);
   localparam logic [CW-1:0] AE_TH    = CW'(ALMOST_EMPTY_TH);

   logic          pop_ok;
   logic          push_ok;
   logic          overflow;
   logic          underflow;
   logic [CW-1:0] count_next;
   flags_t        flags_next;

   // Acceptance uses pre-edge flags; a pop frees a slot so a push on full is still taken.
   always_comb begin
      pop_ok     = 1'b0;
      push_ok    = 1'b0;
      overflow   = 1'b0;
      underflow  = 1'b0;
      count_next = count;
      flags_next = '0;

      pop_ok    = pop & ~fifo_empty & ~reset;
      push_ok   = push & (~fifo_full | pop_ok) & ~reset;
      overflow  = push & fifo_full & ~pop_ok;
      underflow = pop & fifo_empty;

      if (reset) begin
         count_next = '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
         endcase
      end

      flags_next.full         = (count_next == FULL_CNT);
      flags_next.empty        = (count_next == '0);
      flags_next.almost_full  = (count_next >= AF_TH);
      flags_next.almost_empty = (count_next <= AE_TH);
   end

   assign write_enable = push_ok;
   assign read_enable  = pop_ok;

   fifo_ctrl_ptr_counter #(.W(ADDR_WIDTH)) u_write_ptr (
      .clk   (clk),
      .reset (reset),
      .en    (push_ok),
      .ptr   (write_ptr)
   );

   fifo_ctrl_ptr_counter #(.W(ADDR_WIDTH)) u_read_ptr (
      .clk   (clk),
      .reset (reset),
      .en    (pop_ok),
      .ptr   (read_ptr)
   );

   always_ff @(posedge clk) begin
      count        <= count_next;
      fifo_full    <= flags_next.full;
      fifo_empty   <= flags_next.empty;
      almost_full  <= flags_next.almost_full;
      almost_empty <= flags_next.almost_empty;
      if (reset) begin
         data_valid <= 1'b0;
         fifo_error <= 1'b0;
      end else begin
         data_valid <= pop_ok;
         if (overflow || underflow) begin
            fifo_error <= 1'b1;
         end
      end
   end

endmodule
